// File: rtl/arbitro_polinomio_if.sv
// Bus between the requesting clients, the round-robin scheduler and the
// shared polynomial evaluator core. The scheduler takes the slave modport.
// The client/core side takes the master modport.
interface arbitro_polinomio_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  logic [N_REQ-1:0]   req;
  logic [W*N_REQ-1:0] req_x;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic [W*N_REQ-1:0] req_c;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       res_out;
  logic               ovf_out;
  logic               err_out;
  logic               busy;
  logic               core_inicio;
  logic [W-1:0]       core_x;
  logic [W-1:0]       core_a;
  logic [W-1:0]       core_b;
  logic [W-1:0]       core_c;
  logic [W-1:0]       core_res;
  logic               core_pronto;
  logic               core_ovf;

  modport slave (
    input  req, req_x, req_a, req_b, req_c, core_res, core_pronto, core_ovf,
    output grant, done, res_out, ovf_out, err_out, busy,
           core_inicio, core_x, core_a, core_b, core_c
  );

  modport master (
    output req, req_x, req_a, req_b, req_c, core_res, core_pronto, core_ovf,
    input  grant, done, res_out, ovf_out, err_out, busy,
           core_inicio, core_x, core_a, core_b, core_c
  );
endinterface

// File: rtl/arbitro_polinomio.sv
// Round-robin scheduler sharing one polynomial evaluator core among N_REQ
// requesters. It latches the winner's operands and pulses the core start.
// It then waits for pronto, with a timeout, and hands result/overflow/error
// back to the winner with a one-cycle done pulse.
module arbitro_polinomio #(
  parameter int N_REQ   = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input logic             ck,
  input logic             rst,
  arbitro_polinomio_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, owner, winner;
  logic          found;
  logic [TW-1:0] timer;
  logic          seen_low;
  logic          accept, expire;
  logic [W-1:0]  op_x, op_a, op_b, op_c;
  logic [W-1:0]  res_r;
  logic          ovf_r, err_r;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first active request scanning upward from ptr+1, wrapping
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req[IW'(idx)]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  // A pronto counts only after the core has been seen low in this job,
  // so a pronto still high from the previous job is ignored
  always_comb begin
    accept = (state == S_WAIT) && bus.core_pronto && seen_low;
    expire = (state == S_WAIT) && !accept && (timer == TW'(TIMEOUT - 1));
  end

  // Next-state logic for the job sequence IDLE -> START -> WAIT -> DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (accept || expire) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, owner, round-robin pointer, wait timer
  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= IW'(N_REQ - 1);
      owner    <= '0;
      timer    <= '0;
      seen_low <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:  if (found) owner <= winner;
        S_START: begin
          timer    <= '0;
          seen_low <= 1'b0;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (!bus.core_pronto) seen_low <= 1'b1;
        end
        S_DONE:  ptr <= owner;
        default: ;
      endcase
    end
  end

  // Operand latch at arbitration and result capture at job end
  always_ff @(posedge ck) begin
    if (rst) begin
      op_x  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      res_r <= '0;
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (state == S_IDLE && found) begin
        op_x <= bus.req_x[W*int'(winner) +: W];
        op_a <= bus.req_a[W*int'(winner) +: W];
        op_b <= bus.req_b[W*int'(winner) +: W];
        op_c <= bus.req_c[W*int'(winner) +: W];
      end
      if (accept) begin
        res_r <= bus.core_res;
        ovf_r <= bus.core_ovf;
        err_r <= 1'b0;
      end else if (expire) begin
        res_r <= '0;
        ovf_r <= 1'b0;
        err_r <= 1'b1;
      end
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.core_inicio = (state == S_START);
  assign bus.grant       = (state != S_IDLE) ? to_onehot(owner) : '0;
  assign bus.done        = (state == S_DONE) ? to_onehot(owner) : '0;
  assign bus.res_out     = res_r;
  assign bus.ovf_out     = ovf_r;
  assign bus.err_out     = err_r;
  assign bus.core_x      = op_x;
  assign bus.core_a      = op_a;
  assign bus.core_b      = op_b;
  assign bus.core_c      = op_c;

endmodule

// File: tb/tb_arbitro_polinomio.sv
// Directed bench for the round-robin polynomial-core scheduler, with a
// behavioural core computing A*X^2 + B*X + C with selectable response modes.
module tb_arbitro_polinomio;
  localparam int N_REQ   = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 64;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  arbitro_polinomio_if #(.N_REQ(N_REQ), .W(W)) bus ();

  arbitro_polinomio #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .ck (ck),
    .rst(rst),
    .bus(bus)
  );

  int checks     = 0;
  int failures   = 0;
  int inicio_cnt = 0;
  int onehot_err = 0;

  // core model mode: 0 = answers after core_lat cycles, 1 = never answers,
  // 2 = stale pronto held through START, low two cycles, then real answer
  int core_mode = 0;
  int core_lat  = 5;
  int core_cnt  = 0;
  bit core_active = 1'b0;
  logic [W-1:0] mx, ma, mb, mc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] poly(input logic [W-1:0] x, a, b, c);
    return 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
  endfunction

  // behavioural evaluator core
  initial begin
    logic [63:0] full;
    bus.core_pronto = 1'b0;
    bus.core_res    = '0;
    bus.core_ovf    = 1'b0;
    forever begin
      @(negedge ck);
      if (bus.core_inicio) begin
        mx = bus.core_x; ma = bus.core_a; mb = bus.core_b; mc = bus.core_c;
        core_active = 1'b1;
        core_cnt    = 0;
        if (core_mode == 2) bus.core_res = 16'hDEAD;
        else bus.core_pronto = 1'b0;
      end else if (core_active) begin
        core_cnt++;
        if ((core_mode == 0 && core_cnt == core_lat) || (core_mode == 2 && core_cnt == 4)) begin
          full = poly(mx, ma, mb, mc);
          bus.core_res    = full[W-1:0];
          bus.core_ovf    = |full[63:W];
          bus.core_pronto = 1'b1;
          core_active     = 1'b0;
        end else if (core_mode == 2 && core_cnt == 2) begin
          bus.core_pronto = 1'b0;
        end
      end
    end
  end

  // protocol monitor: start pulses and grant one-hot property
  initial begin
    forever begin
      @(negedge ck);
      if (bus.core_inicio) inicio_cnt++;
      if (bus.busy ? !$onehot(bus.grant) : (bus.grant != '0)) onehot_err++;
    end
  end

  task automatic set_ops(input int i, input logic [W-1:0] x, a, b, c);
    bus.req_x[W*i +: W] = x;
    bus.req_a[W*i +: W] = a;
    bus.req_b[W*i +: W] = b;
    bus.req_c[W*i +: W] = c;
  endtask

  task automatic issue(input int i);
    @(negedge ck);
    bus.req[i] = 1'b1;
  endtask

  // lat counts negedges since the request was raised (START cycle = 1)
  task automatic wait_done(input int start, output int idx, output int lat);
    bit seen;
    seen = 1'b0;
    idx  = -1;
    lat  = start;
    while (!seen && lat < start + 300) begin
      @(negedge ck);
      lat++;
      if (bus.done != '0) begin
        seen = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (bus.done[i]) idx = i;
      end
    end
    check_val("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int idx, lat, nd;
    int order [5] = '{0, 1, 2, 3, 0};
    bus.req   = '0;
    bus.req_x = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge ck);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_grant", 32'(bus.grant), 0);
    check_val("rst_done", 32'(bus.done), 0);
    check_val("rst_inicio", 32'(bus.core_inicio), 0);
    check_val("rst_res", 32'(bus.res_out), 0);
    check_val("rst_flags", {30'd0, bus.ovf_out, bus.err_out}, 0);
    check_val("rst_core_x", 32'(bus.core_x), 0);
    rst = 1'b0;

    // single request, 5-cycle core: 1*4 + 3*2 + 4 = 14
    core_mode = 0; core_lat = 5;
    set_ops(0, 16'd2, 16'd1, 16'd3, 16'd4);
    issue(0);
    @(negedge ck);
    check_val("t1_inicio", 32'(bus.core_inicio), 1);
    check_val("t1_grant", 32'(bus.grant), 32'h1);
    bus.req_x[0 +: W] = 16'd7;
    wait_done(1, idx, lat);
    bus.req[0] = 1'b0;
    check_val("t1_idx", idx, 0);
    check_val("t1_lat", lat, 7);
    check_val("t1_res", 32'(bus.res_out), 14);
    check_val("t1_flags", {30'd0, bus.ovf_out, bus.err_out}, 0);
    check_val("t1_core_x", 32'(bus.core_x), 2);
    @(negedge ck);
    check_val("t1_done_1cyc", 32'(bus.done), 0);
    check_val("t1_res_hold", 32'(bus.res_out), 14);
    check_val("t1_inicio_cnt", inicio_cnt, 1);

    // all four held from reset: order 0,1,2,3,0, result = X = i+1
    rst = 1'b1;
    repeat (2) @(negedge ck);
    rst = 1'b0;
    core_lat = 2;
    for (int i = 0; i < N_REQ; i++) set_ops(i, 16'(i + 1), 16'd0, 16'd1, 16'd0);
    bus.req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_done(0, idx, lat);
      check_val($sformatf("t2_order%0d", n), idx, order[n]);
      check_val($sformatf("t2_res%0d", n), 32'(bus.res_out), order[n] + 1);
    end
    bus.req = '0;
    check_val("t2_onehot", onehot_err, 0);

    // core never answers: timeout after TIMEOUT wait cycles
    core_mode = 1;
    set_ops(3, 16'd5, 16'd5, 16'd5, 16'd5);
    issue(3);
    wait_done(0, idx, lat);
    bus.req[3] = 1'b0;
    check_val("t3_idx", idx, 3);
    check_val("t3_lat", lat, TIMEOUT + 2);
    check_val("t3_err", 32'(bus.err_out), 1);
    check_val("t3_res", 32'(bus.res_out), 0);
    check_val("t3_ovf", 32'(bus.ovf_out), 0);
    // healthy core afterwards clears the error: 1+1+1 = 3
    core_mode = 0; core_lat = 3;
    set_ops(3, 16'd1, 16'd1, 16'd1, 16'd1);
    issue(3);
    wait_done(0, idx, lat);
    bus.req[3] = 1'b0;
    check_val("t3b_lat", lat, 5);
    check_val("t3b_err", 32'(bus.err_out), 0);
    check_val("t3b_res", 32'(bus.res_out), 3);

    // stale pronto at START must be rejected: 2*9 + 0 + 5 = 23
    core_mode = 2;
    set_ops(0, 16'd3, 16'd2, 16'd0, 16'd5);
    issue(0);
    wait_done(0, idx, lat);
    bus.req[0] = 1'b0;
    check_val("t4_lat", lat, 6);
    check_val("t4_res", 32'(bus.res_out), 23);
    check_val("t4_err", 32'(bus.err_out), 0);

    // reset during WAIT cycle 3 aborts the job without a done pulse
    core_mode = 0; core_lat = 10;
    set_ops(1, 16'd9, 16'd9, 16'd9, 16'd9);
    issue(1);
    repeat (5) @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    check_val("t5_busy", 32'(bus.busy), 0);
    check_val("t5_grant", 32'(bus.grant), 0);
    check_val("t5_done", 32'(bus.done), 0);
    check_val("t5_res", 32'(bus.res_out), 0);
    rst = 1'b0;
    bus.req[1] = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge ck);
      if (bus.done != '0) nd++;
    end
    check_val("t5_no_done", nd, 0);
    // requester 2 afterwards: 1*4 + 1*2 + 1 = 7
    core_lat = 3;
    set_ops(2, 16'd2, 16'd1, 16'd1, 16'd1);
    issue(2);
    wait_done(0, idx, lat);
    bus.req[2] = 1'b0;
    check_val("t5b_idx", idx, 2);
    check_val("t5b_lat", lat, 5);
    check_val("t5b_res", 32'(bus.res_out), 7);

    // overflow: 0xFFFF * 0xFE01 = 0xFE0001FF, requester drops mid-job
    core_lat = 4;
    set_ops(1, 16'h00FF, 16'hFFFF, 16'd0, 16'd0);
    issue(1);
    repeat (3) @(negedge ck);
    bus.req[1] = 1'b0;
    wait_done(3, idx, lat);
    check_val("t6_idx", idx, 1);
    check_val("t6_lat", lat, 6);
    check_val("t6_ovf", 32'(bus.ovf_out), 1);
    check_val("t6_err", 32'(bus.err_out), 0);
    check_val("t6_res", 32'(bus.res_out), 32'h01FF);
    repeat (3) @(negedge ck);
    check_val("t6_idle", 32'(bus.busy), 0);
    check_val("final_onehot", onehot_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
